tag_lru_array: RTL and testbench
================================

# tag_lru_array

Parametrised N-way cache metadata store: per-set tag, valid bit and true-LRU age state, with registered hit/victim lookup, fill writes and a sequential flush engine. Sits between the cache controller FSM and the data array in the I- and D-caches. Replaces the fixed 2-way, 64-set, 8-bit metadata array and moves hit compare and LRU bookkeeping into the block.

## Interface
- WAYS, 2: associativity; power of two, 2..8. WW = clog2(WAYS).
- SETS, 64: number of sets; power of two, 2..256. SW = clog2(SETS).
- TAG_W, 7: tag width in bits.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_en  in  1  lookup request this cycle.
- lookup_set  in  SW  set index for lookup.
- lookup_tag  in  TAG_W  tag to compare.
- fill_en  in  1  write tag into a way this cycle.
- fill_set  in  SW  set index for fill.
- fill_way  in  WW  way to write.
- fill_tag  in  TAG_W  tag written; valid set to 1.
- flush_req  in  1  single-cycle pulse: invalidate all sets.
- resp_valid  out  1  lookup response valid (one cycle after accepted lookup).
- resp_hit  out  1  tag matched a valid way.
- resp_way  out  WW  matching way (0 on miss).
- resp_victim  out  WW  replacement candidate for that set.
- busy  out  1  flush in progress; lookup/fill ignored.

## Operation
- Storage per set per way: tag[TAG_W], valid, age[WW]. Ages in a set always form a permutation of 0..WAYS-1; 0 = MRU, WAYS-1 = LRU.
- Reset (rst=1 at edge): all valid=0, age of way i = i, busy=0, resp_valid=0, resp_hit=0, resp_way=0, resp_victim=0. Reset mid-flush aborts flush; array left fully cleared.
- Lookup accepted when lookup_en=1 and busy=0. Hit = any way with valid and tag==lookup_tag; at most one way matches (controller guarantees no duplicate fill); resp_way = that way.
- Victim = lowest-index invalid way; if all valid, way with age WAYS-1. Computed from state before this cycle's updates.
- Touch(way w) in set s: every way with age < age[w] increments; age[w] = 0; others unchanged.
- Hit lookup touches hit way. Miss lookup changes no state.
- Fill accepted when fill_en=1 and busy=0: tag/valid written, then touch(fill_way). Fill of an already-valid way overwrites.
- Same-cycle lookup and fill, same set: lookup compares pre-fill contents; fill touch applied, lookup touch dropped. Different sets: both applied.
- Flush: flush_req with busy=0 sets busy=1 next edge; engine walks sets 0..SETS-1, one per cycle, clearing valid and restoring ages to way index. busy drops after last set written. flush_req while busy ignored. A lookup or fill in the same cycle as accepted flush_req is still performed; response delivered normally.
- While busy: lookup_en and fill_en ignored, resp_valid=0.

## Timing
- Lookup latency 1: request at edge N sampled; resp_valid/hit/way/victim registered at edge N+1, held one cycle only (resp_valid=0 next cycle unless new lookup).
- Back-to-back lookups every cycle supported; lookup at N+1 to same set observes LRU update from hit at N.
- Fill visible to lookups issued the cycle after fill.
- Flush: flush_req at edge N; busy=1 for exactly SETS cycles (edges N+1..N+SETS); first lookup accepted at edge N+SETS+1.
- No combinational path from inputs to outputs.

## Test plan
- Reset then lookup set 5 tag 0x12 (WAYS=4) -> resp_valid=1, resp_hit=0, resp_victim=0 next cycle; second lookup same -> identical.
- Fill set 5 ways 0,1,2,3 with tags 0x10..0x13, lookup 0x10 (hit way 0), then lookup 0x7F -> resp_hit=0, resp_victim=1 (way 1 LRU).
- Same-cycle fill set 3 way 2 tag 0x40 and lookup set 3 tag 0x40 -> resp_hit=0; lookup next cycle -> resp_hit=1, resp_way=2.
- Fill all ways of sets 0 and 63, flush_req -> busy high 64 cycles; lookups during busy give resp_valid=0; after busy drops, all lookups miss with resp_victim=0.
- Assert rst on cycle 10 of a flush -> busy=0 next cycle, all sets invalid, lookup at following cycle accepted.
- WAYS=2, SETS=16, TAG_W=9: alternating hits on ways 0/1 with random tags vs reference LRU model for 2000 cycles -> hit, way, victim match every cycle.

Source files
------------

// File: rtl/tag_lru_array.sv
// N-way cache metadata store: per-set tags, valid bits and true-LRU ages,
// with a registered hit/victim lookup, fill writes and a one-set-per-cycle flush.
module tag_lru_array #(
    parameter  int unsigned WAYS  = 2,
    parameter  int unsigned SETS  = 64,
    parameter  int unsigned TAG_W = 7,
    localparam int unsigned WW    = $clog2(WAYS),
    localparam int unsigned SW    = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_en,
    input  logic [SW-1:0]    lookup_set,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic             fill_en,
    input  logic [SW-1:0]    fill_set,
    input  logic [WW-1:0]    fill_way,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             flush_req,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [WW-1:0]    resp_way,
    output logic [WW-1:0]    resp_victim,
    output logic             busy
);

    typedef logic [WAYS-1:0][WW-1:0]    ages_t;
    typedef logic [WAYS-1:0][TAG_W-1:0] tags_t;
    typedef enum logic {IDLE, FLUSH} state_t;

    tags_t           tag_q   [SETS];
    logic [WAYS-1:0] valid_q [SETS];
    ages_t           age_q   [SETS];

    state_t        state, state_next;
    logic [SW-1:0] flush_set;

    logic          lookup_acc, fill_acc, lookup_touch;
    logic          hit, found_invalid;
    logic [WW-1:0] hit_way, victim;

    // Ages of a set after making way w the MRU; younger ways each age by one.
    function automatic ages_t touch(input ages_t a, input logic [WW-1:0] w);
        ages_t r;
        r = a;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (a[i] < a[w]) begin
                r[i] = a[i] + 1'b1;
            end
        end
        r[w] = '0;
        return r;
    endfunction

    function automatic ages_t initial_ages();
        ages_t r;
        for (int unsigned i = 0; i < WAYS; i++) begin
            r[i] = WW'(i);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (flush_req) state_next = FLUSH;
            FLUSH:   if (flush_set == SW'(SETS - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == FLUSH);
    end

    always_comb begin
        lookup_acc   = lookup_en && !busy;
        fill_acc     = fill_en && !busy;
        // A same-set fill owns the LRU update; the lookup's touch is dropped.
        lookup_touch = lookup_acc && hit && !(fill_acc && (fill_set == lookup_set));
    end

    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        victim        = '0;
        found_invalid = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[lookup_set][w] && (tag_q[lookup_set][w] == lookup_tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!valid_q[lookup_set][w] && !found_invalid) begin
                victim        = WW'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[lookup_set][w] == WW'(WAYS - 1)) begin
                    victim = WW'(w);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                tag_q[s]   <= '0;
                valid_q[s] <= '0;
                age_q[s]   <= initial_ages();
            end
            flush_set   <= '0;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_way    <= '0;
            resp_victim <= '0;
        end else begin
            resp_valid  <= lookup_acc;
            resp_hit    <= lookup_acc && hit;
            resp_way    <= lookup_acc ? hit_way : '0;
            resp_victim <= lookup_acc ? victim : '0;
            if (state == FLUSH) begin
                valid_q[flush_set] <= '0;
                age_q[flush_set]   <= initial_ages();
                flush_set          <= flush_set + 1'b1;
            end else begin
                flush_set <= '0;
                if (lookup_touch) begin
                    age_q[lookup_set] <= touch(age_q[lookup_set], hit_way);
                end
                if (fill_acc) begin
                    tag_q[fill_set][fill_way]   <= fill_tag;
                    valid_q[fill_set][fill_way] <= 1'b1;
                    age_q[fill_set]             <= touch(age_q[fill_set], fill_way);
                end
            end
        end
    end

endmodule

// File: tb/tb_tag_lru_array.sv
// Bench for tag_lru_array: a 4-way/64-set instance driven with directed
// vectors and a 2-way/16-set instance driven randomly, both against a recency-list model.
module tb_tag_lru_array;

    logic clk;
    logic rst;

    logic       l0_en, f0_en, fr0;
    logic [5:0] l0_set, f0_set;
    logic [6:0] l0_tag, f0_tag;
    logic [1:0] f0_way;
    logic       rv0, hit0, busy0;
    logic [1:0] way0, vic0;

    logic       l1_en, f1_en, fr1;
    logic [3:0] l1_set, f1_set;
    logic [8:0] l1_tag, f1_tag;
    logic [0:0] f1_way;
    logic       rv1, hit1, busy1;
    logic [0:0] way1, vic1;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_on   = 0;

    tag_lru_array #(.WAYS(4), .SETS(64), .TAG_W(7)) dut4 (
        .clk(clk), .rst(rst),
        .lookup_en(l0_en), .lookup_set(l0_set), .lookup_tag(l0_tag),
        .fill_en(f0_en), .fill_set(f0_set), .fill_way(f0_way), .fill_tag(f0_tag),
        .flush_req(fr0),
        .resp_valid(rv0), .resp_hit(hit0), .resp_way(way0), .resp_victim(vic0),
        .busy(busy0)
    );

    tag_lru_array #(.WAYS(2), .SETS(16), .TAG_W(9)) dut2 (
        .clk(clk), .rst(rst),
        .lookup_en(l1_en), .lookup_set(l1_set), .lookup_tag(l1_tag),
        .fill_en(f1_en), .fill_set(f1_set), .fill_way(f1_way), .fill_tag(f1_tag),
        .flush_req(fr1),
        .resp_valid(rv1), .resp_hit(hit1), .resp_way(way1), .resp_victim(vic1),
        .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per set, a recency list of ways (index 0 = most recent).
    int m_tag [2][64][8];
    bit m_val [2][64][8];
    int m_ord [2][64][8];
    int m_cnt [2];
    bit e_rv [2];
    bit e_hit [2];
    bit e_busy [2];
    int e_way [2];
    int e_vic [2];

    function automatic int nw(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int ns(input int i);
        return (i == 0) ? 64 : 16;
    endfunction

    task automatic clear_inst(input int i);
        for (int s = 0; s < 64; s++) begin
            for (int k = 0; k < 8; k++) begin
                m_val[i][s][k] = 0;
                m_tag[i][s][k] = 0;
                m_ord[i][s][k] = k;
            end
        end
    endtask

    task automatic move_front(input int i, input int s, input int w);
        int p = 0;
        for (int k = 0; k < nw(i); k++) begin
            if (m_ord[i][s][k] == w) p = k;
        end
        for (int k = p; k > 0; k--) m_ord[i][s][k] = m_ord[i][s][k-1];
        m_ord[i][s][0] = w;
    endtask

    task automatic model_step(input int i, input bit r, input bit le, input int ls, input int lt,
                              input bit fe, input int fs, input int fw, input int ft, input bit fr);
        int hw = -1;
        int vic = -1;
        if (r) begin
            clear_inst(i);
            m_cnt[i] = 0;
            e_rv[i] = 0; e_hit[i] = 0; e_way[i] = 0; e_vic[i] = 0; e_busy[i] = 0;
            return;
        end
        if (m_cnt[i] > 0) begin
            m_cnt[i]--;
            e_rv[i] = 0;
            e_busy[i] = (m_cnt[i] > 0);
            return;
        end
        e_rv[i] = le;
        if (le) begin
            for (int w = 0; w < nw(i); w++) begin
                if (m_val[i][ls][w] && m_tag[i][ls][w] == lt) hw = w;
            end
            for (int w = nw(i) - 1; w >= 0; w--) begin
                if (!m_val[i][ls][w]) vic = w;
            end
            if (vic < 0) vic = m_ord[i][ls][nw(i) - 1];
            e_hit[i] = (hw >= 0);
            e_way[i] = (hw >= 0) ? hw : 0;
            e_vic[i] = vic;
        end
        if (le && hw >= 0 && !(fe && fs == ls)) move_front(i, ls, hw);
        if (fe) begin
            m_tag[i][fs][fw] = ft;
            m_val[i][fs][fw] = 1;
            move_front(i, fs, fw);
        end
        // Nothing can be observed while busy, so the whole array is cleared up front.
        if (fr) begin
            m_cnt[i] = ns(i);
            clear_inst(i);
        end
        e_busy[i] = (m_cnt[i] > 0);
    endtask

    always @(posedge clk) begin
        model_step(0, rst, l0_en, int'(l0_set), int'(l0_tag), f0_en, int'(f0_set), int'(f0_way), int'(f0_tag), fr0);
        model_step(1, rst, l1_en, int'(l1_set), int'(l1_tag), f1_en, int'(f1_set), int'(f1_way), int'(f1_tag), fr1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("m0_resp_valid", 32'(rv0), 32'(e_rv[0]));
            check("m0_busy", 32'(busy0), 32'(e_busy[0]));
            if (e_rv[0]) begin
                check("m0_hit", 32'(hit0), 32'(e_hit[0]));
                check("m0_way", 32'(way0), e_way[0]);
                check("m0_victim", 32'(vic0), e_vic[0]);
            end
            check("m1_resp_valid", 32'(rv1), 32'(e_rv[1]));
            check("m1_busy", 32'(busy1), 32'(e_busy[1]));
            if (e_rv[1]) begin
                check("m1_hit", 32'(hit1), 32'(e_hit[1]));
                check("m1_way", 32'(way1), e_way[1]);
                check("m1_victim", 32'(vic1), e_vic[1]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        l0_en = 0; f0_en = 0; fr0 = 0;
        l1_en = 0; f1_en = 0; fr1 = 0;
    endtask

    task automatic lk0(input logic [5:0] s, input logic [6:0] t);
        l0_en = 1; l0_set = s; l0_tag = t;
        tick();
    endtask

    task automatic fl0(input logic [5:0] s, input logic [1:0] w, input logic [6:0] t);
        f0_en = 1; f0_set = s; f0_way = w; f0_tag = t;
        tick();
    endtask

    task automatic expect0(input string name, input logic rv, input logic h, input logic [1:0] w, input logic [1:0] v);
        check({name, "_valid"}, 32'(rv0), 32'(rv));
        check({name, "_hit"}, 32'(hit0), 32'(h));
        check({name, "_way"}, 32'(way0), 32'(w));
        check({name, "_victim"}, 32'(vic0), 32'(v));
    endtask

    initial begin
        #300000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete, got stalled expected done");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int n;
        rst = 1;
        l0_en = 0; l0_set = '0; l0_tag = '0; f0_en = 0; f0_set = '0; f0_way = '0; f0_tag = '0; fr0 = 0;
        l1_en = 0; l1_set = '0; l1_tag = '0; f1_en = 0; f1_set = '0; f1_way = '0; f1_tag = '0; fr1 = 0;
        tick();
        tick();
        chk_on = 1;
        expect0("reset", 0, 0, 2'd0, 2'd0);
        check("reset_busy", 32'(busy0), 0);
        rst = 0;

        lk0(6'd5, 7'h12);
        expect0("empty_lookup", 1, 0, 2'd0, 2'd0);
        lk0(6'd5, 7'h12);
        expect0("empty_lookup2", 1, 0, 2'd0, 2'd0);

        for (int w = 0; w < 4; w++) fl0(6'd5, 2'(w), 7'(8'h10 + w));
        lk0(6'd5, 7'h10);
        expect0("hit_way0", 1, 1, 2'd0, 2'd0);
        lk0(6'd5, 7'h7F);
        expect0("miss_lru1", 1, 0, 2'd0, 2'd1);

        f0_en = 1; f0_set = 6'd3; f0_way = 2'd2; f0_tag = 7'h40;
        lk0(6'd3, 7'h40);
        expect0("same_cycle_fill", 1, 0, 2'd0, 2'd0);
        lk0(6'd3, 7'h40);
        expect0("after_fill", 1, 1, 2'd2, 2'd0);

        for (int w = 0; w < 4; w++) fl0(6'd0, 2'(w), 7'(8'h20 + w));
        for (int w = 0; w < 4; w++) fl0(6'd63, 2'(w), 7'(8'h30 + w));
        fr0 = 1;
        lk0(6'd0, 7'h20);
        expect0("flush_cycle_lookup", 1, 1, 2'd0, 2'd0);
        check("flush_busy_rise", 32'(busy0), 1);
        n = 0;
        while (busy0 && n < 200) begin
            l0_en = 1; l0_set = 6'd63; l0_tag = 7'h33;
            tick();
            n++;
            if (n == 1) check("busy_lookup_ignored", 32'(rv0), 0);
        end
        check("flush_busy_cycles", n, 64);
        lk0(6'd0, 7'h20);
        expect0("post_flush_set0", 1, 0, 2'd0, 2'd0);
        lk0(6'd63, 7'h33);
        expect0("post_flush_set63", 1, 0, 2'd0, 2'd0);
        lk0(6'd5, 7'h11);
        expect0("post_flush_set5", 1, 0, 2'd0, 2'd0);

        f0_en = 1; f0_set = 6'd7; f0_way = 2'd1; f0_tag = 7'h55;
        fr0 = 1;
        tick();
        for (int k = 0; k < 9; k++) tick();
        rst = 1;
        tick();
        rst = 0;
        check("abort_busy", 32'(busy0), 0);
        check("abort_valid", 32'(rv0), 0);
        lk0(6'd7, 7'h55);
        expect0("abort_lookup", 1, 0, 2'd0, 2'd0);
        fl0(6'd9, 2'd3, 7'h66);
        lk0(6'd9, 7'h66);
        expect0("abort_refill", 1, 1, 2'd3, 2'd0);

        for (int c = 0; c < 2000; c++) begin
            l1_en  = ($urandom_range(0, 9) < 8);
            l1_set = 4'($urandom_range(0, 3));
            l1_tag = {8'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            f1_en  = ($urandom_range(0, 9) < 3);
            f1_set = 4'($urandom_range(0, 3));
            f1_way = 1'($urandom_range(0, 1));
            // Low tag bit equals the way, so no two ways of a set ever share a tag.
            f1_tag = {8'($urandom_range(0, 3)), f1_way};
            fr1    = (c == 1000);
            tick();
        end
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
